cdbus_csr_arbiter: RTL and testbench
====================================

# cdbus_csr_arbiter

Two-requester arbiter sharing a single cdbus controller's 8-bit CSR port. Typical requesters are a host CPU bridge and a hardware frame-loader, both of which need the same cdbus instance. The block serialises their reads and writes with round-robin fairness, generates `chip_select`, and returns read data after the downstream read latency. It sits between the requesters and one cdbus instance, in the cdbus clock domain.

## Interface
- `READ_LATENCY`, default 1: cycles from the downstream `csr_read` strobe to valid `csr_readdata`; legal range 0..3.
- `clk`  in  1  block clock, shared with cdbus.
- `reset`  in  1  asynchronous, active-high reset.
- `m0_addr`, `m1_addr`  in  5  requester CSR address.
- `m0_read`, `m1_read`  in  1  read request, held until accepted.
- `m0_write`, `m1_write`  in  1  write request, held until accepted.
- `m0_wdata`, `m1_wdata`  in  8  write data, held with the request.
- `m0_waitrequest`, `m1_waitrequest`  out  1  low for exactly the acceptance cycle.
- `m0_rdata`, `m1_rdata`  out  8  read data, registered.
- `m0_rdata_valid`, `m1_rdata_valid`  out  1  one-cycle pulse qualifying rdata.
- `m0_lock`, `m1_lock`  in  1  grant-hold request; present only with `CDBUS_ARB_LOCK_EN`.
- `chip_select`  out  1  to cdbus.
- `csr_address`  out  5  to cdbus.
- `csr_read`, `csr_write`  out  1  to cdbus.
- `csr_writedata`  out  8  to cdbus.
- `csr_readdata`  in  8  from cdbus.

## Operation
- **Requester protocol.** A requester asserts read or write with stable address and data until it sees waitrequest low at a clock edge. Read and write asserted together is treated as a write.
- **States.**
  - `IDLE`: arbitrate.
  - `ISSUE`: one cycle; the downstream strobe is high and the granted requester's waitrequest is low.
  - `RD_WAIT`: count `READ_LATENCY` cycles.
- **Transitions.**
  - `IDLE` → `ISSUE` when any request is pending.
  - `ISSUE` → `IDLE` for a write.
  - `ISSUE` → `RD_WAIT` for a read. When `READ_LATENCY` = 0, `csr_readdata` is captured at the end of `ISSUE` and the FSM goes directly to `IDLE`.
  - `RD_WAIT` → `IDLE` after capture.
- **Arbitration.**
  - Single request: granted.
  - Both requesting: grant the requester not granted last.
  - The `last` pointer updates at every `ISSUE`.
- **Latching.** Address, write data and direction are latched into the downstream registers at the `IDLE` → `ISSUE` edge. Requester inputs are ignored after that edge.
- **Read return.** Read data is registered into `mX_rdata` and `mX_rdata_valid` pulses for 1 cycle, only to the requester that issued the read. `mX_rdata` holds its value until the next read by that requester.
- **`chip_select`.** High during `ISSUE` and `RD_WAIT`, low otherwise.
- **Waitrequest.** High in every cycle except the acceptance cycle.
- **Reset values** (asynchronous, at any point including mid-read):
  - all `csr_*` outputs and `chip_select` = 0;
  - `mX_waitrequest` = 1;
  - `mX_rdata` = 0;
  - `mX_rdata_valid` = 0;
  - state = `IDLE`;
  - `last` = m1, so m0 wins the first contention.
- **Reset mid-read:** the in-flight read is dropped and no rdata_valid is produced.

## Timing
- **Write:** request seen in cycle T (`IDLE`); strobe and acceptance in T+1; `IDLE` again in T+2. Maximum throughput is 1 access per 2 cycles.
- **Read with latency L:**
  - strobe in T+1;
  - downstream data valid in T+1+L;
  - rdata_valid in T+2+L;
  - the FSM is in `IDLE` in that same cycle, so the next issue is at T+3+L.
- **Lost arbitration:** a request keeps waitrequest high and stays pending. Starvation bound: at most one access from the other requester before it is served.

## Configuration
- **`CDBUS_ARB_LOCK_EN` defined:**
  - `mX_lock` ports exist and are sampled at acceptance.
  - Accepting an access with lock=1 makes that requester owner: only the owner is granted in `IDLE`, and the other requester waits.
  - Ownership ends when the owner has an access accepted with lock=0.
  - Reset clears ownership.
- **`CDBUS_ARB_LOCK_EN` undefined:** the lock ports are absent and arbitration is pure round-robin.

## Structure
- **Package `cdbus_arb_pkg`:**
  - state encoding (`IDLE`, `ISSUE`, `RD_WAIT`);
  - `CSR_ADDR_W` = 5;
  - `CSR_DATA_W` = 8;
  - latency-counter width = 2.
- **Sub-module `cdbus_arb_rr`:** a two-way round-robin picker. Inputs: request vector, last pointer, and lock owner/valid. Output: one-hot grant. It is purely combinational, with the pointer register in the parent.

## Test plan
- **Single write.** m0 writes 0x5A to addr 0x03 → `csr_write` high exactly one cycle with addr 0x03 and data 0x5A; `m0_waitrequest` low in that same cycle; `chip_select` high in that same cycle.
- **Simultaneous contention.** m0 and m1 assert writes in the same cycle after reset → m0 is served first, then m1; the strobes are 2 cycles apart.
- **Read latency sweep.** For `READ_LATENCY` = 0, 1 and 3, m1 reads addr 0x10 while the model returns 0xC3 → `m1_rdata` = 0xC3 with rdata_valid pulsed exactly 2+L cycles after the request-seen cycle; m0 sees no valid.
- **Sustained fairness.** Both requesters issue 8 back-to-back reads → grants strictly alternate; each requester completes 8 reads; rdata stays in order per requester.
- **Reset mid-read.** Reset asserted during `RD_WAIT` with L=3 → all outputs take their reset values asynchronously; no rdata_valid follows; the next m1 write after release completes normally.
- **Lock hold (`CDBUS_ARB_LOCK_EN`).**
  - m0 issues 3 writes, the first two with lock=1, while m1 requests continuously → m1 is not served until after m0's third write.
  - Without the macro, the same traffic alternates.

Source files
------------

// File: rtl/cdbus_arb_pkg.sv
// Shared types and widths for the cdbus CSR arbiter.
// The optional grant-hold feature is enabled with the CDBUS_ARB_LOCK_EN macro.
package cdbus_arb_pkg;

    localparam int CSR_ADDR_W = 5;
    localparam int CSR_DATA_W = 8;
    localparam int LAT_CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } arb_state_e;

    // Everything captured from the winning requester at the IDLE -> ISSUE edge.
    typedef struct packed {
        logic [CSR_ADDR_W-1:0] addr;
        logic [CSR_DATA_W-1:0] wdata;
        logic                  is_write;
        logic                  lock;
    } csr_req_t;

endpackage

// File: rtl/cdbus_arb_rr.sv
// Two-way round-robin picker with optional lock owner; purely combinational.
// The last-grant pointer and the owner state live in the parent.
module cdbus_arb_rr (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       lock_valid_i,
    input  logic       lock_owner_i,
    output logic [1:0] gnt_o
);

    logic [1:0] eff_req;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        eff_req = req_i;
        if (lock_valid_i) begin
            eff_req = req_i & (lock_owner_i ? 2'b10 : 2'b01);
        end
        gnt_o = eff_req;
        if (&eff_req) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/cdbus_csr_arbiter.sv
// Serialises two requesters onto one cdbus CSR port with round-robin fairness.
// Define CDBUS_ARB_LOCK_EN to add the mX_lock grant-hold ports.
module cdbus_csr_arbiter
    import cdbus_arb_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CSR_ADDR_W-1:0] m0_addr,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [CSR_DATA_W-1:0] m0_wdata,
    output logic                  m0_waitrequest,
    output logic [CSR_DATA_W-1:0] m0_rdata,
    output logic                  m0_rdata_valid,
    input  logic [CSR_ADDR_W-1:0] m1_addr,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [CSR_DATA_W-1:0] m1_wdata,
    output logic                  m1_waitrequest,
    output logic [CSR_DATA_W-1:0] m1_rdata,
    output logic                  m1_rdata_valid,
`ifdef CDBUS_ARB_LOCK_EN
    input  logic                  m0_lock,
    input  logic                  m1_lock,
`endif
    output logic                  chip_select,
    output logic [CSR_ADDR_W-1:0] csr_address,
    output logic                  csr_read,
    output logic                  csr_write,
    output logic [CSR_DATA_W-1:0] csr_writedata,
    input  logic [CSR_DATA_W-1:0] csr_readdata
);

    // RD_WAIT counts down from READ_LATENCY-1; legal READ_LATENCY is 0..3.
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
        (READ_LATENCY > 0) ? LAT_CNT_W'(READ_LATENCY - 1) : '0;
    localparam logic [LAT_CNT_W-1:0] CNT_ONE = 1;

    arb_state_e           state_q, state_d;
    csr_req_t             req_q, req_d;
    logic                 gnt_q, gnt_d;
    logic                 last_q, last_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 owner_valid_q, owner_valid_d;
    logic                 owner_q, owner_d;
    logic                 capture;

    logic [CSR_DATA_W-1:0] m0_rdata_q, m1_rdata_q;
    logic                  m0_valid_q, m1_valid_q;

    logic [1:0] req_vec;
    logic [1:0] gnt_vec;
    logic [1:0] lock_in;

`ifdef CDBUS_ARB_LOCK_EN
    assign lock_in = {m1_lock, m0_lock};
`else
    assign lock_in = 2'b00;
`endif

    assign req_vec = {m1_read | m1_write, m0_read | m0_write};

    cdbus_arb_rr u_rr (
        .req_i        (req_vec),
        .last_i       (last_q),
        .lock_valid_i (owner_valid_q),
        .lock_owner_i (owner_q),
        .gnt_o        (gnt_vec)
    );

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        gnt_d         = gnt_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        owner_valid_d = owner_valid_q;
        owner_d       = owner_q;
        capture       = 1'b0;

        case (state_q)
            IDLE: begin
                if (|gnt_vec) begin
                    state_d = ISSUE;
                    gnt_d   = gnt_vec[1];
                    if (gnt_vec[1]) begin
                        req_d = '{addr: m1_addr, wdata: m1_wdata, is_write: m1_write, lock: lock_in[1]};
                    end else begin
                        req_d = '{addr: m0_addr, wdata: m0_wdata, is_write: m0_write, lock: lock_in[0]};
                    end
                end
            end
            ISSUE: begin
                last_d        = gnt_q;
                owner_valid_d = req_q.lock;
                owner_d       = gnt_q;
                if (req_q.is_write) begin
                    state_d = IDLE;
                end else if (READ_LATENCY == 0) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            req_q         <= '0;
            gnt_q         <= 1'b0;
            last_q        <= 1'b1;
            cnt_q         <= '0;
            owner_valid_q <= 1'b0;
            owner_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            gnt_q         <= gnt_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            owner_valid_q <= owner_valid_d;
            owner_q       <= owner_d;
        end
    end

    // NOTE: the returned-data registers are reset as well, because requesters observe them as zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_valid_q <= 1'b0;
            m1_valid_q <= 1'b0;
        end else begin
            m0_valid_q <= capture && !gnt_q;
            m1_valid_q <= capture && gnt_q;
            if (capture && !gnt_q) m0_rdata_q <= csr_readdata;
            if (capture && gnt_q)  m1_rdata_q <= csr_readdata;
        end
    end

    assign chip_select    = (state_q != IDLE);
    assign csr_read       = (state_q == ISSUE) && !req_q.is_write;
    assign csr_write      = (state_q == ISSUE) && req_q.is_write;
    assign csr_address    = req_q.addr;
    assign csr_writedata  = req_q.wdata;
    assign m0_waitrequest = !((state_q == ISSUE) && !gnt_q);
    assign m1_waitrequest = !((state_q == ISSUE) && gnt_q);
    assign m0_rdata       = m0_rdata_q;
    assign m1_rdata       = m1_rdata_q;
    assign m0_rdata_valid = m0_valid_q;
    assign m1_rdata_valid = m1_valid_q;

endmodule

// File: tb/tb_cdbus_csr_arbiter.sv
// Directed bench for cdbus_csr_arbiter: three instances (READ_LATENCY 0, 1, 3)
// share requester inputs; each has its own latency-accurate downstream model.
module tb_cdbus_csr_arbiter;

    logic       clk;
    logic       reset;
    logic [4:0] m0_addr, m1_addr;
    logic       m0_read, m1_read, m0_write, m1_write;
    logic [7:0] m0_wdata, m1_wdata;
`ifdef CDBUS_ARB_LOCK_EN
    logic       m0_lock, m1_lock;
`endif

    logic [2:0]      m0_wait, m1_wait, m0_vld, m1_vld, cs, c_rd, c_wr;
    logic [2:0][7:0] m0_rd, m1_rd, c_wd;
    logic [2:0][4:0] c_addr;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
        logic [7:0] rdata_model;

        cdbus_csr_arbiter #(.READ_LATENCY(L)) u_dut (
            .clk            (clk),
            .reset          (reset),
            .m0_addr        (m0_addr),
            .m0_read        (m0_read),
            .m0_write       (m0_write),
            .m0_wdata       (m0_wdata),
            .m0_waitrequest (m0_wait[k]),
            .m0_rdata       (m0_rd[k]),
            .m0_rdata_valid (m0_vld[k]),
            .m1_addr        (m1_addr),
            .m1_read        (m1_read),
            .m1_write       (m1_write),
            .m1_wdata       (m1_wdata),
            .m1_waitrequest (m1_wait[k]),
            .m1_rdata       (m1_rd[k]),
            .m1_rdata_valid (m1_vld[k]),
`ifdef CDBUS_ARB_LOCK_EN
            .m0_lock        (m0_lock),
            .m1_lock        (m1_lock),
`endif
            .chip_select    (cs[k]),
            .csr_address    (c_addr[k]),
            .csr_read       (c_rd[k]),
            .csr_write      (c_wr[k]),
            .csr_writedata  (c_wd[k]),
            .csr_readdata   (rdata_model)
        );

        // Downstream returns addr^0xD3 exactly L cycles after the read strobe, 0xEE otherwise.
        if (L == 0) begin : g_comb
            assign rdata_model = c_rd[k] ? ({3'b000, c_addr[k]} ^ 8'hD3) : 8'hEE;
        end else begin : g_pipe
            logic [L-1:0] pv;
            logic [4:0]   pa [L];
            always @(posedge clk) begin
                pv[0] <= c_rd[k];
                pa[0] <= c_addr[k];
                for (int i = 1; i < L; i++) begin
                    pv[i] <= pv[i-1];
                    pa[i] <= pa[i-1];
                end
            end
            assign rdata_model = pv[L-1] ? ({3'b000, pa[L-1]} ^ 8'hD3) : 8'hEE;
        end
    end

    function automatic int lat(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_cs"},    cs[k],     0);
            check({tag, "_rd"},    c_rd[k],   0);
            check({tag, "_wr"},    c_wr[k],   0);
            check({tag, "_addr"},  c_addr[k], 0);
            check({tag, "_wdata"}, c_wd[k],   0);
            check({tag, "_wait0"}, m0_wait[k], 1);
            check({tag, "_wait1"}, m1_wait[k], 1);
            check({tag, "_rdat0"}, m0_rd[k],  0);
            check({tag, "_rdat1"}, m1_rd[k],  0);
            check({tag, "_vld0"},  m0_vld[k], 0);
            check({tag, "_vld1"},  m1_vld[k], 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, n1, v0, v1, idx, n_exp, g, exp_gnt;
        logic [4:0] exp_seq;

        reset = 1'b1;
        m0_addr = '0; m1_addr = '0; m0_read = 0; m1_read = 0;
        m0_write = 0; m1_write = 0; m0_wdata = '0; m1_wdata = '0;
`ifdef CDBUS_ARB_LOCK_EN
        m0_lock = 0; m1_lock = 0;
`endif
        tick(); tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();

        // Contention straight after reset: m0 first, m1 two cycles later.
        m0_write = 1; m0_addr = 5'h01; m0_wdata = 8'h11;
        m1_write = 1; m1_addr = 5'h02; m1_wdata = 8'h22;
        tick();
        check("cont_a_wr", c_wr[1], 1);
        check("cont_a_addr", c_addr[1], 5'h01);
        check("cont_a_data", c_wd[1], 8'h11);
        check("cont_a_wait0", m0_wait[1], 0);
        check("cont_a_wait1", m1_wait[1], 1);
        m0_write = 0;
        tick();
        check("cont_gap_wr", c_wr[1], 0);
        check("cont_gap_cs", cs[1], 0);
        check("cont_gap_wait1", m1_wait[1], 1);
        tick();
        check("cont_b_wr", c_wr[1], 1);
        check("cont_b_addr", c_addr[1], 5'h02);
        check("cont_b_data", c_wd[1], 8'h22);
        check("cont_b_wait1", m1_wait[1], 0);
        check("cont_b_wait0", m0_wait[1], 1);
        m1_write = 0;
        tick();

        // Single write.
        m0_write = 1; m0_addr = 5'h03; m0_wdata = 8'h5A;
        tick();
        check("wr_strobe", c_wr[1], 1);
        check("wr_rd", c_rd[1], 0);
        check("wr_addr", c_addr[1], 5'h03);
        check("wr_data", c_wd[1], 8'h5A);
        check("wr_wait0", m0_wait[1], 0);
        check("wr_cs", cs[1], 1);
        m0_write = 0;
        tick();
        check("wr_after_strobe", c_wr[1], 0);
        check("wr_after_cs", cs[1], 0);
        check("wr_after_wait0", m0_wait[1], 1);

        // Read latency sweep: valid exactly 2+L cycles after the request-seen cycle.
        m1_read = 1; m1_addr = 5'h10;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("lat_issue_rd", c_rd[k], 1);
            check("lat_issue_wait1", m1_wait[k], 0);
            check("lat_issue_addr", c_addr[k], 5'h10);
        end
        m1_read = 0;
        for (int c = 2; c <= 6; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                check("lat_vld1", m1_vld[k], (c == 2 + lat(k)) ? 1 : 0);
                check("lat_vld0", m0_vld[k], 0);
                check("lat_cs", cs[k], (c <= 1 + lat(k)) ? 1 : 0);
                if (c == 2 + lat(k)) check("lat_rdata1", m1_rd[k], 8'hC3);
            end
        end
        for (int k = 0; k < 3; k++) begin
            check("lat_hold_rdata1", m1_rd[k], 8'hC3);
            check("lat_rdata0", m0_rd[k], 0);
        end

        // Reset while the L=3 instance is in RD_WAIT.
        m1_read = 1; m1_addr = 5'h05;
        tick();
        m1_read = 0;
        tick();
        check("mid_cs_before", cs[2], 1);
        #2 reset = 1'b1;
        #1 check_reset_vals("midrst");
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("midrst_no_vld1", m1_vld[2], 0);
            check("midrst_no_vld0", m0_vld[2], 0);
            check("midrst_cs", cs[2], 0);
        end
        m1_write = 1; m1_addr = 5'h07; m1_wdata = 8'h9C;
        tick();
        check("post_wr", c_wr[2], 1);
        check("post_addr", c_addr[2], 5'h07);
        check("post_data", c_wd[2], 8'h9C);
        check("post_wait1", m1_wait[2], 0);
        m1_write = 0;
        tick();
        check("post_idle_wr", c_wr[2], 0);

        // Sustained fairness on the L=1 instance: 8 reads each, strictly alternating.
        n0 = 0; n1 = 0; v0 = 0; v1 = 0; exp_gnt = 0;
        m0_read = 1; m0_addr = 5'd0;
        m1_read = 1; m1_addr = 5'd16;
        for (int cyc = 0; cyc < 100 && !(v0 == 8 && v1 == 8); cyc++) begin
            tick();
            check("fair_one_accept", !m0_wait[1] && !m1_wait[1], 0);
            if (!m0_wait[1] || !m1_wait[1]) begin
                g = m0_wait[1] ? 1 : 0;
                check("fair_grant", g, exp_gnt);
                exp_gnt = 1 - g;
            end
            if (!m0_wait[1]) begin
                n0++;
                if (n0 == 8) m0_read = 0; else m0_addr = 5'(n0);
            end
            if (!m1_wait[1]) begin
                n1++;
                if (n1 == 8) m1_read = 0; else m1_addr = 5'(16 + n1);
            end
            if (m0_vld[1]) begin
                check("fair_rdata0", m0_rd[1], {3'b000, 5'(v0)} ^ 8'hD3);
                v0++;
            end
            if (m1_vld[1]) begin
                check("fair_rdata1", m1_rd[1], {3'b000, 5'(16 + v1)} ^ 8'hD3);
                v1++;
            end
        end
        m0_read = 0; m1_read = 0;
        check("fair_reads0", v0, 8);
        check("fair_reads1", v1, 8);
        check("fair_accepts0", n0, 8);
        check("fair_accepts1", n1, 8);

        // Lock hold: m0 writes three times (first two locked) while m1 keeps requesting.
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`ifdef CDBUS_ARB_LOCK_EN
        exp_seq = 5'b01000; n_exp = 4;
        m0_lock = 1;
`else
        exp_seq = 5'b01010; n_exp = 5;
`endif
        n0 = 0; idx = 0;
        m0_write = 1; m0_addr = 5'h0A; m0_wdata = 8'hA0;
        m1_write = 1; m1_addr = 5'h0B; m1_wdata = 8'hB0;
        for (int cyc = 0; cyc < 60 && idx < n_exp; cyc++) begin
            tick();
            check("lock_one_accept", !m0_wait[1] && !m1_wait[1], 0);
            if (!m0_wait[1]) begin
                check("lock_grant", 0, exp_seq[idx]);
                idx++;
                n0++;
                if (n0 == 3) begin
                    m0_write = 0;
                end else begin
                    m0_addr = m0_addr + 5'd1;
`ifdef CDBUS_ARB_LOCK_EN
                    m0_lock = (n0 < 2);
`endif
                end
            end else if (!m1_wait[1]) begin
                check("lock_grant", 1, exp_seq[idx]);
                idx++;
            end
        end
        m0_write = 0; m1_write = 0;
`ifdef CDBUS_ARB_LOCK_EN
        m0_lock = 0;
`endif
        check("lock_grants_seen", idx, n_exp);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
